// File: rtl/aes_dec_scheduler_if.sv
// Bus bundle between the crypto front end, the decryption scheduler and the AES-128 core.
// Handshakes (reqN, rsp) transfer on a rising edge where valid and ready are both high.
interface aes_dec_scheduler_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_key;
  logic [127:0] req0_text;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_key;
  logic [127:0] req1_text;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id;
  logic         rsp_err;

  logic         core_en;
  logic         core_rst;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic [127:0] core_result;
  logic         core_done;

  logic         busy;
  logic [7:0]   err_count;
  logic [1:0]   dbg_state;

  modport slave (
    input  req0_valid, req0_key, req0_text,
    input  req1_valid, req1_key, req1_text,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready,
    output core_en, core_rst, core_key, core_text,
    input  core_result, core_done,
    output busy, err_count, dbg_state
  );

  modport master (
    output req0_valid, req0_key, req0_text,
    output req1_valid, req1_key, req1_text,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready,
    input  core_en, core_rst, core_key, core_text,
    output core_result, core_done,
    input  busy, err_count, dbg_state
  );
endinterface

// File: rtl/aes_dec_scheduler.sv
// Round-robin scheduler sharing one AES-128 decryption core between two requesters,
// with a watchdog that flushes the core and returns an error response on a stuck job.
module aes_dec_scheduler #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic            clk,
  input logic            rst,
  aes_dec_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    RESP  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t       state;
  state_t       stateNext;
  logic         lastGrant;
  logic         grantId;
  logic         accept;
  logic [127:0] keyReg;
  logic [127:0] textReg;
  logic [127:0] rspDataReg;
  logic         idReg;
  logic         rspErrReg;
  logic [15:0]  wdCount;
  logic [7:0]   errCount;

  // On contention the requester not served last wins; a lone requester always wins.
  always_comb begin
    grantId = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grantId = ~lastGrant;
    end else begin
      grantId = bus.req1_valid;
    end
  end

  assign accept = (state == IDLE) && (bus.req0_valid || bus.req1_valid);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.core_en    = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          bus.req0_ready = ~grantId;
          bus.req1_ready = grantId;
          stateNext      = RUN;
        end
      end
      RUN: begin
        bus.core_en = 1'b1;
        if (bus.core_done) begin
          stateNext = RESP;
        end else if (wdCount == WD_LAST) begin
          stateNext = FLUSH;
        end
      end
      FLUSH: begin
        stateNext = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Job context and response registers; the core sees the latched job for the whole RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lastGrant  <= 1'b1;
      keyReg     <= '0;
      textReg    <= '0;
      idReg      <= 1'b0;
      rspDataReg <= '0;
      rspErrReg  <= 1'b0;
      wdCount    <= '0;
      errCount   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            keyReg    <= grantId ? bus.req1_key : bus.req0_key;
            textReg   <= grantId ? bus.req1_text : bus.req0_text;
            idReg     <= grantId;
            lastGrant <= grantId;
            wdCount   <= '0;
          end
        end
        RUN: begin
          wdCount <= wdCount + 16'd1;
          if (bus.core_done) begin
            rspDataReg <= bus.core_result;
            rspErrReg  <= 1'b0;
          end
        end
        FLUSH: begin
          rspDataReg <= '0;
          rspErrReg  <= 1'b1;
          if (errCount != 8'hFF) begin
            errCount <= errCount + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.core_rst  = ~rst | (state == FLUSH);
  assign bus.core_key  = keyReg;
  assign bus.core_text = textReg;
  assign bus.rsp_data  = rspDataReg;
  assign bus.rsp_id    = idReg;
  assign bus.rsp_err   = rspErrReg;
  assign bus.busy      = (state != IDLE);
  assign bus.err_count = errCount;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Directed bench for aes_dec_scheduler with a behavioural core model and a response scoreboard.
module tb_aes_dec_scheduler;
  localparam int TIMEOUT = 16;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [129:0] exp_q[$];
  logic [129:0] popped;
  int cyc = 0;
  int rsp_count = 0;
  int ready0_cnt = 0;
  int rst_high = 0;
  int flush_cyc = 0;
  int grant_cyc = 0;
  int low_cnt = 0;
  bit seen_en = 1'b0;
  bit core_hang = 1'b0;
  int core_lat = 8;
  int core_cnt;

  aes_dec_scheduler_if bus();

  aes_dec_scheduler #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_model(input logic [127:0] key, input logic [127:0] text);
    if (key == K0 && text == C0) return P0;
    return text ^ {key[63:0], key[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model: result strobe core_lat cycles into an enabled run, never when hung.
  initial begin
    core_cnt <= 0;
    bus.core_done <= 1'b0;
    bus.core_result <= '0;
    forever begin
      @(posedge clk);
      if (bus.core_rst || !bus.core_en) begin
        core_cnt <= 0;
        bus.core_done <= 1'b0;
      end else begin
        core_cnt <= core_cnt + 1;
        if (!core_hang && core_cnt == core_lat - 1) begin
          bus.core_done <= 1'b1;
          bus.core_result <= core_model(bus.core_key, bus.core_text);
        end else begin
          bus.core_done <= 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: ready/core_rst counters, core_en idle gap, response scoreboard.
  initial forever begin
    @(negedge clk);
    if (bus.req0_ready) ready0_cnt++;
    if (rst && bus.core_rst) begin
      rst_high++;
      flush_cyc = cyc;
    end
    if (bus.core_en) begin
      if (seen_en && low_cnt != 0) check("core_en_gap", 128'(low_cnt >= 2), 128'(1));
      seen_en = 1'b1;
      low_cnt = 0;
    end else begin
      low_cnt++;
    end
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 128'(1), 128'(0));
      end else begin
        popped = exp_q.pop_front();
        check("rsp_id", 128'(bus.rsp_id), 128'(popped[129]));
        check("rsp_err", 128'(bus.rsp_err), 128'(popped[128]));
        check("rsp_data", bus.rsp_data, popped[127:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic send(input bit id, input logic [127:0] key, input logic [127:0] text,
                      input bit push_exp, input bit exp_err);
    bit found;
    @(posedge clk);
    #2;
    core_lat = $urandom_range(3, 12);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_key = key; bus.req1_text = text;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_key = key; bus.req0_text = text;
    end
    if (push_exp) exp_q.push_back({id, exp_err, exp_err ? 128'h0 : core_model(key, text)});
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("send_grant", 128'(found), 128'(1));
    grant_cyc = cyc;
    @(posedge clk);
    #2;
    if (id) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 500; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(tag, 128'(exp_q.size()), 128'(0));
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] key0, key1, text0, text1, bp_data;
    bit found, g;
    int bad, r0, rh, c0, rc;

    bus.req0_valid = 1'b0; bus.req0_key = '0; bus.req0_text = '0;
    bus.req1_valid = 1'b0; bus.req1_key = '0; bus.req1_text = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_core_rst", 128'(bus.core_rst), 128'(1));
    check("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("reset_core_en", 128'(bus.core_en), 128'(0));
    check("reset_busy", 128'(bus.busy), 128'(0));
    check("reset_err_count", 128'(bus.err_count), 128'(0));
    check("reset_rsp_data", bus.rsp_data, 128'h0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Contention: both requesters valid for four jobs
    bus.rsp_ready = 1'b1;
    key0 = {$urandom, $urandom, $urandom, $urandom};
    key1 = {$urandom, $urandom, $urandom, $urandom};
    text0 = {$urandom, $urandom, $urandom, $urandom};
    text1 = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #2;
    bus.req0_valid = 1'b1; bus.req0_key = key0; bus.req0_text = text0;
    bus.req1_valid = 1'b1; bus.req1_key = key1; bus.req1_text = text1;
    for (int j = 0; j < 4; j++) begin
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (bus.req0_ready || bus.req1_ready) begin
          found = 1'b1;
          break;
        end
      end
      check("cont_grant_seen", 128'(found), 128'(1));
      check("cont_one_hot", 128'(bus.req0_ready & bus.req1_ready), 128'(0));
      g = bus.req1_ready;
      check("cont_grant_order", 128'(g), 128'(j % 2));
      exp_q.push_back({g, 1'b0, g ? core_model(key1, text1) : core_model(key0, text0)});
      @(posedge clk);
      #2;
      if (j == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else if (g) begin
        text1 = {$urandom, $urandom, $urandom, $urandom};
        bus.req1_text = text1;
      end else begin
        text0 = {$urandom, $urandom, $urandom, $urandom};
        bus.req0_text = text0;
      end
    end
    wait_drain("cont_drain");

    // Single job with the known-answer vector
    r0 = ready0_cnt;
    send(1'b0, K0, C0, 1'b1, 1'b0);
    wait_drain("single_drain");
    check("single_ready_cycles", 128'(ready0_cnt - r0), 128'(1));

    // Backpressure: consumer stalls 20 cycles while req1 waits
    bus.rsp_ready = 1'b0;
    key0 = {$urandom, $urandom, $urandom, $urandom};
    text0 = {$urandom, $urandom, $urandom, $urandom};
    bp_data = core_model(key0, text0);
    send(1'b0, key0, text0, 1'b1, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("bp_rsp_valid", 128'(found), 128'(1));
    @(posedge clk);
    #2;
    key1 = {$urandom, $urandom, $urandom, $urandom};
    text1 = {$urandom, $urandom, $urandom, $urandom};
    bus.req1_valid = 1'b1; bus.req1_key = key1; bus.req1_text = text1;
    exp_q.push_back({1'b1, 1'b0, core_model(key1, text1)});
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== bp_data || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0 ||
          bus.req0_ready || bus.req1_ready || bus.core_en) bad++;
    end
    check("bp_stable_cycles", 128'(bad), 128'(0));
    @(posedge clk);
    #2 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_state", 128'(bus.dbg_state), 128'(0));
    check("bp_req1_grant", 128'(bus.req1_ready), 128'(1));
    @(posedge clk);
    #2 bus.req1_valid = 1'b0;
    wait_drain("bp_drain");

    // Watchdog: core never strobes
    core_hang = 1'b1;
    rh = rst_high;
    send(1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
    c0 = grant_cyc;
    wait_drain("wd_drain");
    check("wd_core_rst_cycles", 128'(rst_high - rh), 128'(1));
    check("wd_core_rst_delay", 128'(flush_cyc - c0), 128'(17));
    check("wd_err_count", 128'(bus.err_count), 128'(1));
    core_hang = 1'b0;
    send(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    wait_drain("wd_next_drain");

    // Reset ten cycles into a job
    core_hang = 1'b1;
    send(1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst_core_rst", 128'(bus.core_rst), 128'(1));
    rc = rsp_count;
    @(posedge clk);
    #2 rst = 1'b1;
    core_hang = 1'b0;
    @(negedge clk);
    check("midrst_state", 128'(bus.dbg_state), 128'(0));
    check("midrst_core_en", 128'(bus.core_en), 128'(0));
    check("midrst_core_rst_off", 128'(bus.core_rst), 128'(0));
    check("midrst_core_key", bus.core_key, 128'h0);
    check("midrst_core_text", bus.core_text, 128'h0);
    check("midrst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("midrst_rsp_data", bus.rsp_data, 128'h0);
    check("midrst_rsp_id", 128'(bus.rsp_id), 128'(0));
    check("midrst_rsp_err", 128'(bus.rsp_err), 128'(0));
    check("midrst_busy", 128'(bus.busy), 128'(0));
    check("midrst_err_count", 128'(bus.err_count), 128'(0));
    repeat (5) @(negedge clk);
    check("midrst_no_rsp", 128'(rsp_count - rc), 128'(0));
    send(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    wait_drain("midrst_next_drain");

    // Saturation of the abort counter
    core_hang = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send(1'(i % 2), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
      wait_drain("sat_drain");
    end
    check("sat_err_count", 128'(bus.err_count), 128'(255));
    core_hang = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_dec_scheduler.md
# aes_dec_scheduler

Shares one AES-128 decryption core between two requesters. Round-robin arbitration selects a requester, latches its key and ciphertext, and sequences the core's enable/reset. The block waits for the core's result strobe and returns the plaintext on a valid/ready response port tagged with the requester ID. A watchdog aborts and flushes the core if no result arrives. Sits between the packet-level crypto front end and the decryption core.

## Interface
- TIMEOUT_CYCLES, 1023: cycles in RUN without a result strobe before the job is aborted; legal range 16..65535.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this cycle
- req0_key  in  128  requester 0 cipher key
- req0_text  in  128  requester 0 ciphertext
- req1_valid / req1_ready / req1_key / req1_text: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  128  plaintext (0 on error)
- rsp_id  out  1  requester that owns the response
- rsp_err  out  1  job aborted by watchdog
- core_en  out  1  to core enable
- core_rst  out  1  to core reset (active-high, synchronous)
- core_key  out  128  to core byteKey
- core_text  out  128  to core byteText
- core_result  in  128  from core resultantOutput
- core_done  in  1  from core initialStep (result strobe)
- busy  out  1  high in any state except IDLE
- err_count  out  8  saturating count of watchdog aborts

## Operation
- States: IDLE, RUN, RESP, FLUSH.
- IDLE: core_en=0.
  - If any reqN_valid: grant by round-robin, set reqN_ready=1 combinationally for the granted requester only, latch key/text/ID, go to RUN.
  - If both are valid, grant the requester not granted last.
  - last_grant resets to 1, so requester 0 wins the first contention.
- RUN: core_en=1; core_key/core_text hold the latched values and stay stable; watchdog counts up from 0.
  - If core_done=1: capture core_result into rsp_data, set rsp_err=0, go to RESP.
  - Else if watchdog == TIMEOUT_CYCLES-1: go to FLUSH.
- FLUSH: one cycle, core_en=0, core_rst=1. Then set rsp_data=0, rsp_err=1, increment err_count (saturates at 255), go to RESP.
- RESP: core_en=0, rsp_valid=1; rsp_data/rsp_id/rsp_err held stable. On rsp_ready=1 go to IDLE.
  - core_en therefore stays low for at least 2 cycles between jobs. The core needs this to return to its load phase.
- core_rst = (~rst) | (state==FLUSH).
- A core_done pulse outside RUN is ignored.
- reqN_ready is never high outside IDLE. Requests arriving while busy wait; there is no queue.
- Reset (rst=0 at a clock edge), including mid-job: state=IDLE, last_grant=1, all data registers 0, watchdog 0, err_count 0, core_rst=1. An in-flight job is dropped with no response.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, core_en=0, core_rst=1 (while rst=0), core_key=0, core_text=0, busy=0, err_count=0.
- Handshake cycle T0 (IDLE, valid&ready) → RUN from T1, core_en high from T1.
- core_done at cycle Tn → rsp_valid high at Tn+1, core_en low at Tn+1.
- Response taken at edge with rsp_valid&rsp_ready → IDLE next cycle. The earliest next grant is in that IDLE cycle, so back-to-back job spacing is ≥1 IDLE cycle.
- Timeout path: RUN for exactly TIMEOUT_CYCLES cycles, FLUSH for 1 cycle, then RESP.
- Scheduler overhead per job: 3 cycles plus core latency, excluding consumer stall.

## Test plan
- Single job, real core: req0 sends key 000102030405060708090a0b0c0d0e0f and text 69c4e0d86a7b0430d8cdb78070b4c55a. Required: rsp_data=00112233445566778899aabbccddeeff, rsp_id=0, rsp_err=0; req0_ready high exactly 1 cycle.
- Contention: req0 and req1 valid continuously for 4 jobs, rsp_ready=1. Required: grant order 0,1,0,1; each rsp_id matches its job's plaintext; core_en low ≥2 cycles between jobs.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid. Required: rsp_* stable, reqN_ready=0 throughout, core_en=0; one IDLE cycle after release.
- Watchdog: core model never asserts core_done, TIMEOUT_CYCLES=16. Required: core_rst high exactly 1 cycle, 17 cycles after the grant. Then rsp_err=1, rsp_data=0, err_count=1. The next job completes normally.
- Reset mid-RUN: drive rst=0 for 1 cycle 10 cycles into a job. Required: all outputs at reset values next cycle, no response emitted, and the next req1 job returns the correct plaintext.
- Saturation: 260 forced timeouts. Required: err_count=255.
